// File: rtl/alu_arbiter.sv
// Round-robin two-requester sequencer for the shared ALU: one operation in flight, tagged response.
// Optional illegal-opcode short-circuit enabled by defining ALU_ARB_ILLEGAL_CHK_EN.
module alu_arbiter #(
  parameter int unsigned DW      = 32,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic            elk,
  input  logic            rst_n,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [5:0]      req_sel,
  input  logic [2*DW-1:0] req_a,
  input  logic [2*DW-1:0] req_b,
  output logic [2:0]      alu_sel,
  output logic [DW-1:0]   alu_a,
  output logic [DW-1:0]   alu_b,
  input  logic [DW-1:0]   alu_res,
  input  logic            alu_z,
  input  logic            alu_c,
  input  logic            alu_v,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [DW-1:0]   rsp_res,
  output logic [2:0]      rsp_zcv,
  output logic            rsp_err,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] LAT4 = 4'(ALU_LAT);

  state_t          state;
  state_t          state_nxt;
  logic            rr_ptr;
  logic [3:0]      cnt;
  logic [1:0]      grant;
  logic            gnt_id;
  logic [2:0]      sel_g;
  logic [DW-1:0]   a_g;
  logic [DW-1:0]   b_g;
  logic            hs;
  logic            illegal_g;
  logic            lat_hit;

  // Grant selection: a lone requester wins outright, a tie goes to rr_ptr.
  always_comb begin
    grant = '0;
    unique case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = rr_ptr ? 2'b10 : 2'b01;
      default: grant = '0;
    endcase
  end

  always_comb begin
    gnt_id = grant[1];
    sel_g  = gnt_id ? req_sel[5:3]       : req_sel[2:0];
    a_g    = gnt_id ? req_a[2*DW-1:DW]   : req_a[DW-1:0];
    b_g    = gnt_id ? req_b[2*DW-1:DW]   : req_b[DW-1:0];
  end

`ifdef ALU_ARB_ILLEGAL_CHK_EN
  assign illegal_g = sel_g[2] & (sel_g[1] | sel_g[0]);
`else
  assign illegal_g = 1'b0;
`endif

  assign req_ready = (rst_n && state == IDLE) ? grant : '0;
  assign hs        = (state == IDLE) && (grant != 2'b00);
  assign lat_hit   = (cnt == LAT4);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (hs) state_nxt = illegal_g ? RESP : EXEC;
      EXEC:    if (lat_hit) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // alu_* double as the issue registers, so they naturally hold outside EXEC.
  always_ff @(posedge elk) begin
    if (!rst_n) begin
      state   <= IDLE;
      rr_ptr  <= 1'b0;
      cnt     <= '0;
      alu_sel <= '0;
      alu_a   <= '0;
      alu_b   <= '0;
      rsp_id  <= 1'b0;
      rsp_res <= '0;
      rsp_zcv <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (hs) begin
            rsp_id <= gnt_id;
            cnt    <= '0;
            if (illegal_g) begin
              rsp_res <= '0;
              rsp_zcv <= '0;
            end else begin
              alu_sel <= sel_g;
              alu_a   <= a_g;
              alu_b   <= b_g;
            end
          end
        end
        EXEC: begin
          cnt <= cnt + 4'd1;
          if (lat_hit) begin
            rsp_res <= alu_res;
            rsp_zcv <= {alu_z, alu_c, alu_v};
          end
        end
        RESP: begin
          if (rsp_ready) rr_ptr <= ~rsp_id;
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_ARB_ILLEGAL_CHK_EN
  always_ff @(posedge elk) begin
    if (!rst_n) begin
      rsp_err <= 1'b0;
    end else if (hs) begin
      rsp_err <= illegal_g;
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed cases plus randomized traffic against a
// behavioural ALU/arbitration model; define ALU_ARB_ILLEGAL_CHK_EN to match the DUT build.
module tb_alu_arbiter;
  localparam int DW      = 32;
  localparam int ALU_LAT = 1;

  logic            elk;
  logic            rst_n;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [5:0]      req_sel;
  logic [2*DW-1:0] req_a;
  logic [2*DW-1:0] req_b;
  logic [2:0]      alu_sel;
  logic [DW-1:0]   alu_a;
  logic [DW-1:0]   alu_b;
  logic [DW-1:0]   alu_res;
  logic            alu_z, alu_c, alu_v;
  logic            rsp_valid;
  logic            rsp_ready;
  logic            rsp_id;
  logic [DW-1:0]   rsp_res;
  logic [2:0]      rsp_zcv;
  logic            rsp_err;
  logic            busy;

  alu_arbiter #(.DW(DW), .ALU_LAT(ALU_LAT)) dut (
    .elk(elk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
    .req_a(req_a), .req_b(req_b),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b),
    .alu_res(alu_res), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_res(rsp_res), .rsp_zcv(rsp_zcv), .rsp_err(rsp_err), .busy(busy)
  );

  typedef struct packed {
    logic [2:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  typedef struct {
    logic        id;
    logic [31:0] res;
    logic [2:0]  zcv;
    logic        err;
    int          cyc;
  } exp_t;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  op_t  q0[$];
  op_t  q1[$];
  op_t  cur_op[2];
  logic [1:0] rv;
  logic [1:0] hs_last;
  int   gap_pct;
  bit   rsp_mode;

  exp_t exp_q[$];
  exp_t cur_exp;
  bit   inflight;
  bit   presenting;
  logic rr;
  logic [66:0]  mdl_alu;
  logic [105:0] hold;
  logic rst_prev;

  initial elk = 1'b0;
  always #5 elk = ~elk;
  always @(posedge elk) cyc++;

  // Reference ALU: plain arithmetic, result packed as {z, c, v, res}.
  function automatic logic [34:0] alu_f(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] t;
    logic [31:0] r;
    logic c, v;
    t = '0; r = '0; c = 1'b0; v = 1'b0;
    case (s)
      3'd0: begin
        t = {1'b0, a} + {1'b0, b}; r = t[31:0]; c = t[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      3'd1: begin
        t = {1'b0, a} + {1'b0, ~b} + 33'd1; r = t[31:0]; c = t[32];
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = ~a;
      default: r = '0;
    endcase
    return {(r == 32'd0), c, v, r};
  endfunction

  always_comb {alu_z, alu_c, alu_v, alu_res} = alu_f(alu_sel, alu_a, alu_b);

  function automatic logic [1:0] pred_grant(input logic [1:0] v, input logic p);
    if (v == 2'b01) return 2'b01;
    if (v == 2'b10) return 2'b10;
    if (v == 2'b11) return p ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  assign req_valid = rv;
  assign req_sel   = {cur_op[1].sel, cur_op[0].sel};
  assign req_a     = {cur_op[1].a, cur_op[0].a};
  assign req_b     = {cur_op[1].b, cur_op[0].b};

  // Requester drivers: hold an op until accepted, then fetch the next one.
  initial begin
    rv = '0;
    cur_op[0] = '0;
    cur_op[1] = '0;
    forever begin
      @(posedge elk); #1;
      if (rsp_mode) rsp_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < 2; i++) begin
        if (!rst_n) rv[i] = 1'b0;
        else if (!rv[i] || hs_last[i]) begin
          rv[i] = 1'b0;
          if ($urandom_range(0, 99) >= gap_pct) begin
            if (i == 0 && q0.size() > 0) begin cur_op[0] = q0.pop_front(); rv[0] = 1'b1; end
            if (i == 1 && q1.size() > 0) begin cur_op[1] = q1.pop_front(); rv[1] = 1'b1; end
          end
        end
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    hs_last = '0; inflight = 0; presenting = 0; rr = 1'b0; mdl_alu = '0; rst_prev = 1'b1; hold = '0;
  end

  always @(negedge elk) begin
    logic [1:0] hs;
    op_t        o;
    exp_t       e;
    logic [34:0] r;
    bit         skip;
    hs = req_valid & req_ready;
    hs_last = hs;
    if (!rst_n) begin
      check("rst_ready", 128'(req_ready), 128'd0);
      if (!rst_prev)
        check("rst_outs", 128'({alu_sel, alu_a, alu_b, rsp_valid, rsp_id, rsp_res, rsp_zcv, rsp_err, busy}), 128'd0);
      exp_q.delete();
      inflight = 0; presenting = 0; rr = 1'b0; mdl_alu = '0;
    end else begin
      check("alu_hold", 128'({alu_sel, alu_a, alu_b}), 128'(mdl_alu));
      check("busy", 128'(busy), 128'(inflight));
      if (inflight) check("ready_busy", 128'(req_ready), 128'd0);
      else          check("grant", 128'(req_ready), 128'(pred_grant(req_valid, rr)));
      if (hs != 2'b00) begin
        o = hs[1] ? cur_op[1] : cur_op[0];
        skip = 0;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
        skip = (o.sel >= 3'd5);
`endif
        e.id = hs[1];
        if (skip) begin
          e.res = '0; e.zcv = '0; e.err = 1'b1; e.cyc = cyc + 1;
        end else begin
          r = alu_f(o.sel, o.a, o.b);
          e.res = r[31:0]; e.zcv = r[34:32]; e.err = 1'b0; e.cyc = cyc + 2 + ALU_LAT;
          mdl_alu = {o.sel, o.a, o.b};
        end
        exp_q.push_back(e);
        inflight = 1;
      end
      if (rsp_valid) begin
        if (!presenting) begin
          presenting = 1;
          hold = {alu_sel, alu_a, alu_b, rsp_valid, rsp_id, rsp_res, rsp_zcv, rsp_err, busy};
          if (exp_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL rsp_unexpected: got id %0d res %0h expected no response", rsp_id, rsp_res);
            cur_exp.id = rsp_id;
          end else begin
            cur_exp = exp_q.pop_front();
            check("rsp_lat", 128'(cyc), 128'(cur_exp.cyc));
            check("rsp_id", 128'(rsp_id), 128'(cur_exp.id));
            check("rsp_res", 128'(rsp_res), 128'(cur_exp.res));
            check("rsp_zcv", 128'(rsp_zcv), 128'(cur_exp.zcv));
            check("rsp_err", 128'(rsp_err), 128'(cur_exp.err));
          end
        end else begin
          check("rsp_stable", 128'({alu_sel, alu_a, alu_b, rsp_valid, rsp_id, rsp_res, rsp_zcv, rsp_err, busy}), 128'(hold));
        end
        if (rsp_ready) begin
          rr = ~cur_exp.id;
          inflight = 0;
          presenting = 0;
        end
      end else if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
        vectors++; miscompares++;
        $display("FAIL rsp_timeout: got no rsp_valid expected one by cycle %0d", exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
    end
    rst_prev = rst_n;
  end

  task automatic push(input int i, input logic [2:0] s, input logic [31:0] a, input logic [31:0] b);
    op_t o;
    o.sel = s; o.a = a; o.b = b;
    if (i == 0) q0.push_back(o); else q1.push_back(o);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || rv != 2'b00 || inflight || exp_q.size() != 0) && n < budget) begin
      @(negedge elk); n++;
    end
    vectors++;
    if (n >= budget) begin
      miscompares++;
      $display("FAIL drain_timeout: got still busy after %0d cycles expected idle", n);
    end
  endtask

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    rst_n = 1'b0; rsp_ready = 1'b1; rsp_mode = 0; gap_pct = 0;
    repeat (3) @(posedge elk);
    #1 rst_n = 1'b1;

    push(0, 3'd0, 32'd15, 32'd7);
    wait_idle(50);

    // Both requesters valid straight out of reset: grants must alternate 0,1,0,1.
    @(posedge elk); #1 rst_n = 1'b0;
    push(0, 3'd1, 32'd10, 32'd2); push(0, 3'd1, 32'd10, 32'd2);
    push(1, 3'd2, 32'd10, 32'd0); push(1, 3'd2, 32'd10, 32'd0);
    repeat (2) @(posedge elk);
    #1 rst_n = 1'b1;
    wait_idle(100);

    // Backpressure on the response channel.
    rsp_ready = 1'b0;
    push(1, 3'd0, 32'h7FFF_FFFF, 32'h0000_0001);
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge elk); n++; end
    repeat (5) @(negedge elk);
    @(posedge elk); #1 rsp_ready = 1'b1;
    wait_idle(50);

    push(0, 3'd0, 32'hF000_0000, 32'h8000_0000);
    wait_idle(50);

    // Same op again, reset while it is executing: response must be dropped.
    push(0, 3'd0, 32'hF000_0000, 32'h8000_0000);
    n = 0;
    do begin @(negedge elk); n++; end while ((req_valid & req_ready) == 2'b00 && n < 50);
    @(posedge elk); #1 rst_n = 1'b0;
    repeat (2) @(posedge elk);
    #1 rst_n = 1'b1;
    push(1, 3'd3, 32'd15, 32'd7);
    wait_idle(50);

    push(0, 3'd7, 32'd5, 32'd3);
    wait_idle(50);

    gap_pct = 30; rsp_mode = 1;
    for (int k = 0; k < 150; k++)
      push(int'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), rnd_word(), rnd_word());
    wait_idle(20000);
    rsp_mode = 0; rsp_ready = 1'b1;
    repeat (3) @(posedge elk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion expected $finish before time limit");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and sequencer for the shared 32-bit ALU (ops ADD 000, SUB 001, AND 010, OR 011, NOT 100; flags z/c/v).
- Accepts operations from two independent requesters over valid/ready channels and grants round-robin.
- Drives the ALU from registered operands and waits a fixed, parameterised ALU latency.
- Returns the result and flags on a single tagged response channel with backpressure.
- Sits between the datapath control units and the ALU instance; it is the only block that drives ALU inputs.

## Interface
Parameters:
- DW, 32, operand/result width.
- ALU_LAT, 1, cycles from ALU inputs becoming valid to the cycle whose end samples the ALU result; legal range 0..15.

Ports:
- elk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  2  per-requester operation valid; bit i belongs to requester i.
- req_ready  out  2  per-requester accept; at most one bit high per cycle.
- req_sel  in  6  {sel1, sel0}; 3-bit opcode per requester.
- req_a  in  2*DW  {a1, a0}; operand A per requester.
- req_b  in  2*DW  {b1, b0}; operand B per requester (ignored by the ALU for NOT, still forwarded).
- alu_sel  out  3  opcode to the ALU.
- alu_a  out  DW  operand A to the ALU.
- alu_b  out  DW  operand B to the ALU.
- alu_res  in  DW  ALU result.
- alu_z, alu_c, alu_v  in  1 each  ALU zero/carry/overflow flags.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer accept.
- rsp_id  out  1  requester index that owns the response.
- rsp_res  out  DW  captured result.
- rsp_zcv  out  3  captured flags {z, c, v}.
- rsp_err  out  1  illegal-opcode response (see Configuration).
- busy  out  1  high in any state other than IDLE.

## Operation
FSM states:
- IDLE
  - req_ready = grant vector.
  - With one valid requester, that requester is granted.
  - With both valid, the requester at rr_ptr is granted.
  - On handshake (req_valid[i] & req_ready[i]): latch sel/a/b into issue registers, record id, go to EXEC.
- EXEC
  - alu_sel/alu_a/alu_b driven from the issue registers.
  - 4-bit counter loads 0 on entry and increments each cycle.
  - When counter == ALU_LAT: capture alu_res and {alu_z, alu_c, alu_v} into the rsp_* registers at the end of that cycle, then go to RESP.
- RESP
  - rsp_valid = 1; all rsp_* outputs held stable.
  - On rsp_valid & rsp_ready: go to IDLE and set rr_ptr = ~rsp_id, so the other requester wins the next tie.

Rules:
- req_ready is 0 outside IDLE. One operation is in flight at a time.
- alu_* outputs keep their last value outside EXEC. They never change while an operation is in RESP.
- Flags are passed through from the ALU unmodified. The arbiter does no arithmetic.
- Reset (rst_n sampled low), in any state, including mid-EXEC or in RESP with a pending response:
  - FSM to IDLE, rr_ptr = 0, counter = 0.
  - Any pending response is dropped.
  - Output reset values: req_ready = 00 (forced while rst_n is low), alu_sel = 000, alu_a = alu_b = 0, rsp_valid = 0, rsp_id = 0, rsp_res = 0, rsp_zcv = 000, rsp_err = 0, busy = 0.
- Requester inputs must stay stable while valid and not yet accepted. A requester may drop valid before it is granted; no grant is then issued to it.

## Timing
- Handshake in cycle T. EXEC during cycles T+1 .. T+1+ALU_LAT. rsp_valid first high in cycle T+2+ALU_LAT.
- Minimum spacing between accepts is ALU_LAT+3 cycles (rsp_ready held high).
- With rsp_ready low, RESP is held indefinitely. No new grant is issued until the response is accepted.
- A response accepted in cycle R allows a new handshake no earlier than cycle R+1.

## Configuration
Macro: ALU_ARB_ILLEGAL_CHK_EN.
- Defined:
  - Opcodes 101, 110 and 111 are still accepted, but skip EXEC: the next state after IDLE is RESP.
  - Response: rsp_err = 1, rsp_res = 0, rsp_zcv = 000.
  - alu_* outputs are not updated for these opcodes.
  - rsp_valid is first high in cycle T+1.
- Not defined:
  - All opcodes are forwarded to the ALU and sequenced normally.
  - rsp_err is tied to 0.

## Test plan
- ALU_LAT=1, req0 ADD 15+7 handshake at T -> rsp_valid at T+3, rsp_id 0, rsp_res 22, rsp_zcv 000.
- Both valid from reset and held, req0 SUB 10-2, req1 AND 10&0 -> grants 0,1,0,1. Responses: res 8 with zcv 010; res 0 with zcv 100.
- req1 ADD 7FFFFFFF+00000001 with rsp_ready low for 5 cycles -> rsp_res 80000000, zcv 001. rsp_* are stable throughout, req_ready stays 00, busy=1.
- req0 ADD F0000000+80000000 -> rsp_res 70000000, zcv 011. Repeated with rst_n pulsed low in EXEC -> no rsp_valid, all outputs at reset values. A following req1 OR 15|7 -> res 15, rsp_id 1.
- req0 sel 111 with ALU_ARB_ILLEGAL_CHK_EN -> rsp_valid at T+1, rsp_err 1, res 0, alu_sel unchanged. Without the macro -> alu_sel=111, rsp_err 0, response at T+3.
